// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer scheduler: FSM encoding and layer ids.
// The ERR state exists only when LENET_SCHED_WATCHDOG_EN is defined.
package lenet_pkg;

  localparam int NUM_LAYERS = 5;

  localparam logic [2:0] LAYER_CONV1 = 3'd0;
  localparam logic [2:0] LAYER_CONV2 = 3'd1;
  localparam logic [2:0] LAYER_CONV3 = 3'd2;
  localparam logic [2:0] LAYER_FC1   = 3'd3;
  localparam logic [2:0] LAYER_FC2   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_WRITE,
    S_WRITE_WAIT,
`ifdef LENET_SCHED_WATCHDOG_EN
    S_DONE,
    S_ERR
`else
    S_DONE
`endif
  } sched_state_t;

endpackage

// File: rtl/lenet_sched_wdog.sv
// Cycle counter for the scheduler watchdog; expired is combinational so the
// FSM can leave on the same cycle the limit is reached.
module lenet_sched_wdog #(
  parameter int unsigned WDOG_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) cnt <= '0;
    else if (enable)   cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/lenet_layer_sched.sv
// Sequences CONV1..FC2 through the compute engine, then launches the DMA write.
// Optional watchdog with error exit: define LENET_SCHED_WATCHDOG_EN.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] scale_conv1,
  input  logic [31:0] scale_conv2,
  input  logic [31:0] scale_conv3,
  input  logic [31:0] scale_fc1,
  input  logic [31:0] scale_fc2,
  output logic        layer_start,
  output logic [2:0]  layer_id,
  output logic [31:0] layer_scale,
  input  logic        layer_done,
  output logic        wr_start,
  input  logic        wr_done,
  output logic        busy,
  output logic        sched_done,
  output logic        err
);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  sched_state_t state;
  logic [31:0]  sc [NUM_LAYERS];

`ifdef LENET_SCHED_WATCHDOG_EN
  logic expired;
  logic waiting;

  assign waiting = (state == S_RUN) || (state == S_WRITE_WAIT);

  lenet_sched_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );
`else
  assign err = 1'b0;
`endif

  always_comb begin
    layer_scale = '0;
    case (layer_id)
      LAYER_CONV1: layer_scale = sc[0];
      LAYER_CONV2: layer_scale = sc[1];
      LAYER_CONV3: layer_scale = sc[2];
      LAYER_FC1:   layer_scale = sc[3];
      LAYER_FC2:   layer_scale = sc[4];
      default:     layer_scale = '0;
    endcase
  end

  // Pulse outputs are set on the transition into their state so they are high
  // for exactly the cycle the FSM spends there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      layer_id    <= LAYER_CONV1;
      layer_start <= 1'b0;
      wr_start    <= 1'b0;
      sched_done  <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) sc[i] <= '0;
`ifdef LENET_SCHED_WATCHDOG_EN
      err         <= 1'b0;
`endif
    end else begin
      layer_start <= 1'b0;
      wr_start    <= 1'b0;
      sched_done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sc[0]       <= scale_conv1;
          sc[1]       <= scale_conv2;
          sc[2]       <= scale_conv3;
          sc[3]       <= scale_fc1;
          sc[4]       <= scale_fc2;
          layer_id    <= LAYER_CONV1;
          layer_start <= 1'b1;
          busy        <= 1'b1;
          state       <= S_ISSUE;
`ifdef LENET_SCHED_WATCHDOG_EN
          err         <= 1'b0;
`endif
        end
        S_ISSUE: state <= S_RUN;
        S_RUN: begin
          if (layer_done) begin
            if (layer_id < LAYER_FC2) begin
              layer_id    <= layer_id + 3'd1;
              layer_start <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              wr_start <= 1'b1;
              state    <= S_WRITE;
            end
          end
`ifdef LENET_SCHED_WATCHDOG_EN
          else if (expired) begin
            err        <= 1'b1;
            sched_done <= 1'b1;
            state      <= S_ERR;
          end
`endif
        end
        S_WRITE: state <= S_WRITE_WAIT;
        S_WRITE_WAIT: begin
          if (wr_done) begin
            sched_done <= 1'b1;
            state      <= S_DONE;
          end
`ifdef LENET_SCHED_WATCHDOG_EN
          else if (expired) begin
            err        <= 1'b1;
            sched_done <= 1'b1;
            state      <= S_ERR;
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef LENET_SCHED_WATCHDOG_EN
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Self-checking bench for lenet_layer_sched: reactive engine/DMA stubs driven
// by $urandom delays, checked cycle-by-cycle against an arithmetic timeline model.
module tb_lenet_layer_sched;

  localparam int WDOG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] scale_conv1, scale_conv2, scale_conv3, scale_fc1, scale_fc2;
  logic        layer_start;
  logic [2:0]  layer_id;
  logic [31:0] layer_scale;
  logic        layer_done;
  logic        wr_start;
  logic        wr_done;
  logic        busy;
  logic        sched_done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lenet_layer_sched #(.WDOG_CYCLES(WDOG)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scale_conv1 (scale_conv1),
    .scale_conv2 (scale_conv2),
    .scale_conv3 (scale_conv3),
    .scale_fc1   (scale_fc1),
    .scale_fc2   (scale_fc2),
    .layer_start (layer_start),
    .layer_id    (layer_id),
    .layer_scale (layer_scale),
    .layer_done  (layer_done),
    .wr_start    (wr_start),
    .wr_done     (wr_done),
    .busy        (busy),
    .sched_done  (sched_done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ls"},    layer_start, 0);
    chk({tag, "_id"},    layer_id,    0);
    chk({tag, "_scale"}, layer_scale, 0);
    chk({tag, "_wrs"},   wr_start,    0);
    chk({tag, "_busy"},  busy,        0);
    chk({tag, "_done"},  sched_done,  0);
    chk({tag, "_err"},   err,         0);
  endtask

  task automatic set_scales(input logic [31:0] s [5]);
    scale_conv1 = s[0]; scale_conv2 = s[1]; scale_conv3 = s[2];
    scale_fc1   = s[3]; scale_fc2   = s[4];
  endtask

  // One inference. dly[k]: cycles from layer k's layer_start to its layer_done.
  // abort_l >= 0: pulse reset during that layer's RUN. hold_l >= 0: never
  // answer that layer (watchdog / indefinite wait).
  task automatic run_seq(input string name, input int dly [5], input int wdly,
                         input logic [31:0] sc [5], input bit spur,
                         input int abort_l, input int hold_l);
    int iss [5];
    int wend [5];
    int wcyc, dcyc, errc, last, nls, done_at, wr_at;
    logic [31:0] ff [5];
    bit exp_ls;

    // Timeline: each layer occupies ISSUE + dly cycles of RUN; the write phase
    // is WRITE + wdly cycles of WRITE_WAIT, then one DONE cycle.
    iss[0] = 1;
    for (int k = 1; k < 5; k++) iss[k] = iss[k-1] + dly[k-1] + 1;
    for (int k = 0; k < 5; k++) wend[k] = iss[k] + dly[k];
    wcyc = iss[4] + dly[4] + 1;
    dcyc = wcyc + wdly + 1;
    errc = -1;
    if (hold_l >= 0) begin
      for (int k = hold_l + 1; k < 5; k++) iss[k] = -1;
      wcyc = -1;
`ifdef LENET_SCHED_WATCHDOG_EN
      dcyc = iss[hold_l] + 1 + WDOG;
      errc = dcyc;
      wend[hold_l] = dcyc - 1;
`else
      dcyc = -1;
      wend[hold_l] = iss[hold_l] + 1000;
`endif
    end
    if (abort_l >= 0)    last = iss[abort_l] + 2;
    else if (dcyc >= 0)  last = dcyc + 2;
    else                 last = iss[hold_l] + 1000;

    for (int k = 0; k < 5; k++) ff[k] = 32'hFF;
    nls = 0; done_at = -1; wr_at = -1;

    @(negedge clk);
    set_scales(sc);
    start = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      start = 1'b0; layer_done = 1'b0; wr_done = 1'b0;
      set_scales(ff);

      if (abort_l >= 0 && cyc == last) begin
        chk_all_zero({name, "_rst"});
        rst = 1'b1;
        return;
      end

      exp_ls = 1'b0;
      for (int k = 0; k < 5; k++) if (iss[k] == cyc) exp_ls = 1'b1;
      chk({name, "_layer_start"}, layer_start, exp_ls);
      chk({name, "_wr_start"},    wr_start,   cyc == wcyc);
      chk({name, "_sched_done"},  sched_done, cyc == dcyc);
      chk({name, "_busy"},        busy,       (dcyc < 0) || (cyc <= dcyc));
      chk({name, "_err"},         err,        (errc >= 0) && (cyc >= errc));
      for (int k = 0; k < 5; k++)
        if (iss[k] >= 0 && cyc >= iss[k] && cyc <= wend[k]) begin
          chk({name, "_layer_id"},    layer_id,    k);
          chk({name, "_layer_scale"}, layer_scale, sc[k]);
        end

      if (abort_l >= 0 && cyc == iss[abort_l] + 1) begin
        rst = 1'b0;
        continue;
      end

      // Reactive engine and DMA stubs.
      if (layer_start === 1'b1) begin
        if (nls < 5 && nls != hold_l) done_at = cyc + dly[nls];
        nls++;
      end
      if (wr_start === 1'b1) wr_at = cyc + wdly;
      if (cyc == done_at) layer_done = 1'b1;
      if (cyc == wr_at)   wr_done    = 1'b1;

      if (spur) begin
        if (cyc == iss[2] + 1) start      = 1'b1;
        if (cyc == iss[1])     layer_done = 1'b1;
        if (cyc == wcyc + 1)   layer_done = 1'b1;
        if (cyc == iss[0] + 1) wr_done    = 1'b1;
      end
    end

    if (dcyc < 0) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  initial begin
    int d [5];
    int nom [5];
    logic [31:0] s [5];
    logic [31:0] fix [5];

    rst = 1'b0; start = 1'b0; layer_done = 1'b0; wr_done = 1'b0;
    for (int k = 0; k < 5; k++) s[k] = '0;
    set_scales(s);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    nom = '{3, 3, 3, 3, 3};
    fix = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    run_seq("nominal", nom, 4, fix, 1'b0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) begin
        d[k] = int'($urandom_range(1, 6));
        s[k] = $urandom;
      end
      run_seq("random", d, int'($urandom_range(1, 6)), s, 1'b0, -1, -1);
    end

    for (int k = 0; k < 5; k++) begin
      d[k] = int'($urandom_range(2, 6));
      s[k] = $urandom;
    end
    run_seq("spurious", d, int'($urandom_range(2, 6)), s, 1'b1, -1, -1);

    run_seq("abort_fc1", nom, 4, fix, 1'b0, 3, -1);
    run_seq("after_rst", nom, 4, fix, 1'b0, -1, -1);

    for (int k = 0; k < 5; k++) s[k] = $urandom;
    run_seq("hold_conv2", nom, 4, s, 1'b0, -1, 1);
    run_seq("recover", nom, 4, fix, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
